// File: rtl/led_disp_pkg.sv
// Shared types and constants for the two-digit LED display scheduler.
// Slot encoding, digit-enable patterns and default build parameters live here.
package led_disp_pkg;

  localparam int NUM_SRC_DEF      = 4;
  localparam int SCAN_DIV_DEF     = 8000;
  localparam int BLANK_CYC_DEF    = 64;
  localparam int DWELL_FRAMES_DEF = 500;

  typedef enum logic {
    SLOT_LO = 1'b0,
    SLOT_HI = 1'b1
  } slot_e;

  localparam logic [1:0] DIGIT_EN_OFF = 2'b00;
  localparam logic [1:0] DIGIT_EN_LO  = 2'b01;
  localparam logic [1:0] DIGIT_EN_HI  = 2'b10;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_disp_scheduler_if.sv
// Requester-side bus of the display scheduler: request/byte in, grant/ack out.
interface led_disp_scheduler_if
  import led_disp_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
);

  logic [NUM_SRC-1:0]   req;
  logic [8*NUM_SRC-1:0] value;
  logic [NUM_SRC-1:0]   ack;
  logic [NUM_SRC-1:0]   grant;

  modport master (output req, value, input ack, grant);
  modport slave  (input req, value, output ack, grant);

endinterface

// File: rtl/led_disp_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, ptr itself last.
module rr_arbiter
  import led_disp_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEF,
  localparam int PTR_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!valid && req[(int'(ptr) + k) % NUM_SRC]) begin
        valid  = 1'b1;
        winner = PTR_W'((int'(ptr) + k) % NUM_SRC);
      end
    end
  end

endmodule

// File: rtl/led_disp_scheduler.sv
// Time-shares the two-digit hex display between requesters and scans the digits;
// ownership and the displayed byte only change at frame boundaries.
module led_disp_scheduler
  import led_disp_pkg::*;
#(
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int BLANK_CYC    = BLANK_CYC_DEF,
  parameter int DWELL_FRAMES = DWELL_FRAMES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_disp_scheduler_if.slave  bus,
  output logic [3:0]           nibble,
  output logic [1:0]           digit_en,
  output logic                 blank,
  output logic                 frame_tick
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int DWELL_W = $clog2(DWELL_FRAMES + 1);
  localparam int PTR_W   = idx_width(NUM_SRC);

  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  BLANK_LIM = SCAN_W'(BLANK_CYC);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_FRAMES);
  localparam logic [PTR_W-1:0]   PTR_INIT  = PTR_W'(NUM_SRC - 1);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  slot_e              slot_q, slot_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [3:0]         nibble_q, nibble_d;
  logic [1:0]         digit_en_q, digit_en_d;
  logic               blank_q, blank_d;
  logic               frame_tick_q, frame_tick_d;

  logic               frame_end;
  logic               owner_valid;
  logic               rearb;
  logic [DWELL_W-1:0] dwell_inc;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [NUM_SRC-1:0] arb_onehot;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .winner (arb_idx),
    .valid  (arb_valid)
  );

  always_comb begin
    scan_cnt_d   = scan_cnt_q + 1'b1;
    slot_d       = slot_q;
    dwell_cnt_d  = dwell_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    ack_d        = '0;
    shadow_d     = shadow_q;
    frame_tick_d = 1'b0;

    arb_onehot          = '0;
    arb_onehot[arb_idx] = 1'b1;

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      slot_d     = (slot_q == SLOT_LO) ? SLOT_HI : SLOT_LO;
    end

    frame_end   = (slot_q == SLOT_HI) && (scan_cnt_q == SCAN_LAST);
    owner_valid = |grant_q;
    dwell_inc   = (owner_valid && dwell_cnt_q != DWELL_MAX) ? dwell_cnt_q + 1'b1 : dwell_cnt_q;
    // While a grant is held, rr_ptr_q is the owner's index.
    rearb       = !owner_valid || !bus.req[rr_ptr_q] || (dwell_inc == DWELL_MAX);

    if (frame_end) begin
      frame_tick_d = 1'b1;
      if (!rearb) begin
        dwell_cnt_d = dwell_inc;
        shadow_d    = bus.value[8*int'(rr_ptr_q) +: 8];
        ack_d       = grant_q;
      end else if (arb_valid) begin
        grant_d     = arb_onehot;
        rr_ptr_d    = arb_idx;
        dwell_cnt_d = '0;
        shadow_d    = bus.value[8*int'(arb_idx) +: 8];
        ack_d       = arb_onehot;
      end else begin
        grant_d     = '0;
        dwell_cnt_d = '0;
      end
    end

    // Display outputs are registered from next-state so they align with scan_cnt_q.
    if (scan_cnt_d < BLANK_LIM) begin
      digit_en_d = DIGIT_EN_OFF;
      blank_d    = 1'b1;
    end else begin
      digit_en_d = (slot_d == SLOT_HI) ? DIGIT_EN_HI : DIGIT_EN_LO;
      blank_d    = 1'b0;
    end
    nibble_d = (slot_d == SLOT_HI) ? shadow_d[7:4] : shadow_d[3:0];
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q   <= '0;
      slot_q       <= SLOT_LO;
      dwell_cnt_q  <= '0;
      rr_ptr_q     <= PTR_INIT;
      grant_q      <= '0;
      ack_q        <= '0;
      shadow_q     <= 8'h00;
      nibble_q     <= 4'h0;
      digit_en_q   <= DIGIT_EN_OFF;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      slot_q       <= slot_d;
      dwell_cnt_q  <= dwell_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      shadow_q     <= shadow_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.ack    = ack_q;
  assign nibble     = nibble_q;
  assign digit_en   = digit_en_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_disp_scheduler.sv
// Directed bench for led_disp_scheduler with a short scan (16-cycle slots, 3-frame dwell).
module tb_led_disp_scheduler;

  localparam int NUM_SRC      = 4;
  localparam int SCAN_DIV     = 16;
  localparam int BLANK_CYC    = 4;
  localparam int DWELL_FRAMES = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] nibble;
  logic [1:0] digit_en;
  logic       blank;
  logic       frame_tick;

  led_disp_scheduler_if #(.NUM_SRC(NUM_SRC)) bus ();

  led_disp_scheduler #(
    .NUM_SRC      (NUM_SRC),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .DWELL_FRAMES (DWELL_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .nibble     (nibble),
    .digit_en   (digit_en),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         ph       = 0;     // cycle position inside the 32-cycle frame
  bit         e_tick   = 1'b0;  // frame_tick expected at ph 0 (not in the first frame after reset)
  logic [3:0] e_grant  = '0;    // grant for the current frame; ack equals it at ph 0
  logic [7:0] e_byte   = '0;    // byte the display should be showing this frame

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s t=%0t ph=%0d got=%h exp=%h", tag, $time, ph, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every display/arbitration output for n cycles against the frame expectations.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check("frame_tick", 32'(frame_tick), 32'((ph == 0) && e_tick));
      check("ack",        32'(bus.ack),    (ph == 0) ? 32'(e_grant) : 32'd0);
      check("grant",      32'(bus.grant),  32'(e_grant));
      check("digit_en",   32'(digit_en),
            (ph % SCAN_DIV < BLANK_CYC) ? 32'd0 : ((ph >= SCAN_DIV) ? 32'd2 : 32'd1));
      check("blank",      32'(blank),      32'(ph % SCAN_DIV < BLANK_CYC));
      check("nibble",     32'(nibble),     (ph >= SCAN_DIV) ? 32'(e_byte[7:4]) : 32'(e_byte[3:0]));
      tick();
      ph = (ph + 1) % (2 * SCAN_DIV);
      if (ph == 0) e_tick = 1'b1;
    end
  endtask

  task automatic frame(input logic [3:0] g, input logic [7:0] b);
    e_grant = g;
    e_byte  = b;
    run(2 * SCAN_DIV);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("rst_grant",      32'(bus.grant),  32'd0);
      check("rst_ack",        32'(bus.ack),    32'd0);
      check("rst_digit_en",   32'(digit_en),   32'd0);
      check("rst_blank",      32'(blank),      32'd1);
      check("rst_nibble",     32'(nibble),     32'd0);
      check("rst_frame_tick", 32'(frame_tick), 32'd0);
    end
    rst_n   = 1'b1;
    ph      = 0;
    e_tick  = 1'b0;
    e_grant = '0;
    e_byte  = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.value = '0;

    // Reset and idle scan: blanking, digit order, first frame_tick at cycle 32.
    do_reset(5);
    frame(4'b0000, 8'h00);

    // Lone requester 2 with A5: granted at the next frame end, kept across dwell restart.
    bus.req   = 4'b0100;
    bus.value = 32'h00A5_0000;
    frame(4'b0000, 8'h00);
    for (int f = 0; f < 4; f++) frame(4'b0100, 8'hA5);

    // Steady 1011: 0 -> 1 -> 3 -> 0, three frames each; source 2 never granted.
    do_reset(2);
    bus.value = 32'h4D3C_2B1A;
    bus.req   = 4'b1011;
    frame(4'b0000, 8'h00);
    for (int f = 0; f < 3; f++) frame(4'b0001, 8'h1A);
    for (int f = 0; f < 3; f++) frame(4'b0010, 8'h2B);
    for (int f = 0; f < 3; f++) frame(4'b1000, 8'h4D);
    frame(4'b0001, 8'h1A);

    // Owner 1 drops req mid-frame: grant holds until the frame end, then moves to 3.
    do_reset(2);
    bus.req = 4'b1010;
    frame(4'b0000, 8'h00);
    e_grant = 4'b0010;
    e_byte  = 8'h2B;
    run(10);
    bus.req = 4'b1000;
    run(2 * SCAN_DIV - 10);

    // Owner value 12 -> 34 mid-slot0: display updates only at the following frame end.
    bus.value = 32'h123C_2B1A;
    frame(4'b1000, 8'h4D);
    e_grant = 4'b1000;
    e_byte  = 8'h12;
    run(5);
    bus.value = 32'h343C_2B1A;
    run(2 * SCAN_DIV - 5);
    frame(4'b1000, 8'h34);
    frame(4'b1000, 8'h34);

    // Reset mid-slot1 while source 1 owns the display; source 0 wins first afterwards.
    do_reset(2);
    bus.req = 4'b0010;
    frame(4'b0000, 8'h00);
    e_grant = 4'b0010;
    e_byte  = 8'h2B;
    run(20);
    do_reset(1);
    bus.req = 4'b1111;
    frame(4'b0000, 8'h00);
    frame(4'b0001, 8'h1A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
